// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - LSB-first bit-serial adder/subtractor with start/done handshake
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             last;
   logic             bit_s;
   logic             bit_c;

   // One full-adder slice shared by every bit position.
   always_comb begin
      bit_s = a_sr[0] ^ b_sr[0] ^ carry;
      bit_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
      last  = (cnt == CW'(WIDTH - 1));
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (load) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= {bit_s, r_sr[WIDTH-1:1]};
            carry <= bit_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum  <= {bit_s, r_sr[WIDTH-1:1]};
               cout <= bit_c;
`ifdef SERIAL_ADDSUB_OVF_EN
               // carry still holds the carry into the MSB on this edge
               ovf  <= carry ^ bit_c;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - scoreboard/table bench for serial_addsub at WIDTH=8
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDSUB_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];
   int   done_cyc[$];
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic [7:0] yy;
      logic [8:0] t;
      exp_t       e;
      yy     = s ? ~y : y;
      t      = {1'b0, x} + {1'b0, yy} + {8'd0, s};
      e.sum  = t[7:0];
      e.cout = t[8];
      e.ovf  = (x[7] == yy[7]) && (t[7] != x[7]);
      return e;
   endfunction

   task automatic push_exp(input logic [7:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      sb.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done sum=%0h expected=no done (cycle %0d)", sum, cyc);
         end else begin
            e = sb.pop_front();
            chk("sum", {24'd0, sum}, {24'd0, e.sum});
            chk("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
         end
      end
   endtask

   // Advance one active edge, then sample at the following falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no done after %0d edges expected=done", n);
      end
   endtask

   task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic s);
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
   endtask

   initial begin
      int n;
      exp_t e;
      vecs[0] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
      vecs[1] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
      vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
      vecs[4] = '{a: 8'h00, b: 8'h01, sub: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
      vecs[5] = '{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
      vecs[6] = '{a: 8'h10, b: 8'h20, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
      rst = 1'b0;

      // Exact busy/done timing for a single add.
      drive(8'h5A, 8'h33, 1'b0);
      push_exp(8'h8D, 1'b0, 1'b1);
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         chk("t1_busy", {31'd0, busy}, {31'd0, (i < 8)});
         chk("t1_done", {31'd0, done}, {31'd0, (i == 8)});
      end

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].sub);
         push_exp(vecs[i].sum, vecs[i].cout, vecs[i].ovf);
         tick();
         start = 1'b0;
         wait_done(n);
         chk("tbl_latency", n, 32'd8);
         tick();
      end

      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_sum", {24'd0, sum}, 32'h0000_00F0);
         chk("hold_cout", {31'd0, cout}, 32'd0);
      end

      // start during RUN must be ignored.
      drive(8'h01, 8'h01, 1'b0);
      push_exp(8'h02, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      drive(8'hFF, 8'hFF, 1'b1);
      tick();
      start = 1'b0;
      wait_done(n);
      chk("t4_latency", n, 32'd4);
      for (int i = 0; i < 12; i++) tick();

      // Abort mid-run with reset, then restart on the first edge after release.
      drive(8'h11, 8'h22, 1'b0);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sum", {24'd0, sum}, 32'd0);
      chk("abort_cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      drive(8'h03, 8'h04, 1'b0);
      push_exp(8'h07, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      wait_done(n);
      chk("restart_latency", n, 32'd8);
      tick();
      tick();

      // Back-to-back: start held high, operands change every cycle.
      done_cyc.delete();
      for (int k = 0; k < 37; k++) begin
         drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         if (k % 9 == 0) begin
            e = model(a, b, sub);
            sb.push_back(e);
         end
         tick();
      end
      start = 1'b0;
      wait_done(n);
      chk("b2b_count", done_cyc.size(), 32'd5);
      for (int i = 1; i < done_cyc.size(); i++) begin
         chk("b2b_interval", done_cyc[i] - done_cyc[i-1], 32'd9);
      end
      tick();
      tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=still running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
